// File: rtl/sine_pkg.sv
// Shared constants and types for the quarter-wave sine LUT reader.
// Field positions describe how a phase word splits into quadrant and index.
package sine_pkg;

  localparam int PHASE_W  = 32;
  localparam int ADDR_W   = 9;
  localparam int DATA_W   = 16;

  localparam int QUAD_MSB = PHASE_W - 1;
  localparam int IDX_LSB  = PHASE_W - 2 - ADDR_W;
  localparam int HI_W     = PHASE_W - IDX_LSB;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam int SAMP_W = DATA_W + 1;
  typedef logic signed [SAMP_W-1:0] samp_t;

endpackage

// File: rtl/sine_phase_acc.sv
// Phase accumulator with offset add; emits the decode-relevant phase bits
// (quadrant + index, fraction truncated) and a sample-accept strobe.
module sine_phase_acc
  import sine_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               advance,
  input  logic               clr,
  input  logic [PHASE_W-1:0] tuning_word,
  input  logic [PHASE_W-1:0] phase_offset,
  output logic [HI_W-1:0]    phase_hi,
  output logic               accept
);

  logic [PHASE_W-1:0] r_acc;

  assign accept   = en && advance && !clr;
  assign phase_hi = HI_W'((r_acc + phase_offset) >> IDX_LSB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (clr) begin
      r_acc <= '0;
    end else if (accept) begin
      r_acc <= r_acc + tuning_word;
    end
  end

endmodule

// File: rtl/sine_lut_reader.sv
// Quarter-wave sine ROM read engine: phase -> mirrored address -> signed
// full-wave sample, delivered over a valid/ready stream.
module sine_lut_reader
  import sine_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic               in_ready,
  input  logic               phase_clr,
  input  logic [PHASE_W-1:0] tuning_word,
  input  logic [PHASE_W-1:0] phase_offset,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  output logic [SAMP_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [HI_W-1:0]   w_hi;
  logic              w_accept;
  logic              w_adv;
  logic [1:0]        w_q;
  logic [ADDR_W-1:0] w_idx;
  logic [ADDR_W-1:0] w_addr;
  logic              w_neg;
  logic [DATA_W-1:0] w_s2_dat;
  samp_t             w_mag;

  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_s1_valid;
  logic              r_s1_neg;
  logic              r_s2_valid;
  logic              r_s2_neg;
  logic              r_hold;
  logic [DATA_W-1:0] r_s2_dat;
  samp_t             r_out_data;
  logic              r_out_valid;

  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = w_adv;

  sine_phase_acc u_acc (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .advance      (w_adv),
    .clr          (phase_clr),
    .tuning_word  (tuning_word),
    .phase_offset (phase_offset),
    .phase_hi     (w_hi),
    .accept       (w_accept)
  );

  assign w_q   = w_hi[HI_W-1 -: 2];
  assign w_idx = w_hi[ADDR_W-1:0];
  assign w_neg = w_q[1];

  always_comb begin
    w_addr = w_idx;
    unique case (w_q)
      Q0, Q2:  w_addr = w_idx;
      Q1, Q3:  w_addr = ~w_idx;
      default: w_addr = w_idx;
    endcase
  end

  // While stalled the ROM keeps reading rom_addr, which belongs to stage 1;
  // stage 2's word is latched on the first stall edge and used until release.
  assign w_s2_dat = r_hold ? r_s2_dat : rom_data;
  assign w_mag    = samp_t'({1'b0, w_s2_dat});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_addr  <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_neg    <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_neg    <= 1'b0;
      r_hold      <= 1'b0;
      r_s2_dat    <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (phase_clr) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_hold      <= 1'b0;
    end else if (w_adv) begin
      if (w_accept) begin
        r_rom_addr <= w_addr;
      end
      r_s1_neg    <= w_neg;
      r_s1_valid  <= w_accept;
      r_s2_neg    <= r_s1_neg;
      r_s2_valid  <= r_s1_valid;
      r_hold      <= 1'b0;
      if (r_s2_valid) begin
        r_out_data <= r_s2_neg ? -w_mag : w_mag;
      end
      r_out_valid <= r_s2_valid;
    end else if (!r_hold) begin
      r_hold   <= 1'b1;
      r_s2_dat <= rom_data;
    end
  end

  assign rom_addr  = r_rom_addr;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_sine_lut_reader.sv
// Directed bench for sine_lut_reader with a 1-cycle ROM model lut[i]=i*64.
// Output transfers are collected at negedge into a queue for stream checks.
module tb_sine_lut_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        in_ready;
  logic        phase_clr = 1'b0;
  logic [31:0] tuning_word = '0;
  logic [31:0] phase_offset = '0;
  logic [8:0]  rom_addr;
  logic [15:0] rom_data = '0;
  logic [16:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int total = 0;
  int bad = 0;
  logic signed [31:0] q[$];

  always #5 clk = ~clk;

  sine_lut_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .in_ready     (in_ready),
    .phase_clr    (phase_clr),
    .tuning_word  (tuning_word),
    .phase_offset (phase_offset),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  always @(posedge clk) rom_data <= {1'b0, rom_addr, 6'b0};

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) q.push_back($signed(out_data));

  task automatic check(string tag, logic signed [31:0] obs,
                       logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [31:0] exp_of(logic [31:0] p);
    logic [1:0]  qd;
    logic [8:0]  idx;
    logic [8:0]  a;
    logic signed [31:0] m;
    qd  = p[31:30];
    idx = p[29:21];
    a   = qd[0] ? 9'd511 - idx : idx;
    m   = 32'(a) * 64;
    return qd[1] ? -m : m;
  endfunction

  initial begin
    int acc_n;
    int cyc;
    int exp_a;
    logic st;
    logic [16:0] held;

    // reset state
    #2;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_addr", 32'(rom_addr), 0);
    check("rst_data", $signed(out_data), 0);
    step();
    rst_n = 1'b1;
    check("rst_in_ready", 32'(in_ready), 1);

    // quadrants
    tuning_word = 32'h4000_0000;
    en = 1'b1;
    step();
    check("q_lat0_valid", 32'(out_valid), 0);
    check("q_addr0", 32'(rom_addr), 0);
    step();
    check("q_lat1_valid", 32'(out_valid), 0);
    check("q_addr1", 32'(rom_addr), 511);
    step();
    check("q_lat2_valid", 32'(out_valid), 1);
    check("q_s0", $signed(out_data), 0);
    step();
    check("q_s1", $signed(out_data), 32704);
    step();
    check("q_s2", $signed(out_data), 0);
    step();
    check("q_s3", $signed(out_data), -32704);
    step();
    check("q_s4", $signed(out_data), 0);
    step();
    check("q_s5", $signed(out_data), 32704);
    en = 1'b0;
    repeat (4) step();

    // sweep
    phase_clr = 1'b1;
    step();
    phase_clr = 1'b0;
    q.delete();
    tuning_word = 32'h0020_0000;
    en = 1'b1;
    for (int n = 0; n < 2048; n++) begin
      step();
      exp_a = ((n / 512) % 2 == 0) ? (n % 512) : (511 - n % 512);
      check("sweep_addr", 32'(rom_addr), exp_a);
    end
    en = 1'b0;
    repeat (4) step();
    check("sweep_count", q.size(), 2048);
    for (int n = 0; n < 2048 && n < q.size(); n++)
      check("sweep_val", q[n], exp_of(32'(n) << 21));
    check("sweep_neg_1024", q[1025] < 0, 1);

    // offset and wrap
    phase_clr = 1'b1;
    step();
    phase_clr = 1'b0;
    q.delete();
    phase_offset = 32'h8000_0000;
    tuning_word = 32'h4000_0000;
    en = 1'b1;
    repeat (2) step();
    en = 1'b0;
    repeat (4) step();
    check("off_count", q.size(), 2);
    check("off_s0", q[0], 0);
    check("off_s1", q[1], -32704);
    phase_clr = 1'b1;
    step();
    phase_clr = 1'b0;
    q.delete();
    phase_offset = '0;
    tuning_word = 32'hC000_0000;
    en = 1'b1;
    step();
    tuning_word = 32'h4000_0000;
    repeat (3) step();
    en = 1'b0;
    repeat (4) step();
    check("wrap_count", q.size(), 4);
    check("wrap_s0", q[0], 0);
    check("wrap_s1", q[1], -32704);
    check("wrap_s2", q[2], 0);
    check("wrap_s3", q[3], 32704);

    // backpressure
    phase_clr = 1'b1;
    step();
    phase_clr = 1'b0;
    q.delete();
    tuning_word = 32'h0123_4567;
    phase_offset = 32'h1000_0000;
    acc_n = 0;
    cyc = 0;
    while (acc_n < 40 && cyc < 2000) begin
      out_ready = ($urandom_range(0, 9) < 3);
      en = 1'b1;
      #1;
      st = out_valid && !out_ready;
      held = out_data;
      check("bp_in_ready", 32'(in_ready), 32'(!st));
      if (in_ready) acc_n++;
      step();
      if (st) check("bp_stable", $signed(out_data), $signed(held));
      cyc++;
    end
    en = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();
    check("bp_count", q.size(), 40);
    for (int n = 0; n < 40 && n < q.size(); n++)
      check("bp_val", q[n], exp_of(32'h1000_0000 + 32'(n) * 32'h0123_4567));

    // phase_clr during stall
    phase_clr = 1'b1;
    step();
    phase_clr = 1'b0;
    q.delete();
    tuning_word = 32'h4000_0000;
    phase_offset = 32'h4000_0000;
    out_ready = 1'b0;
    en = 1'b1;
    step();
    en = 1'b0;
    repeat (2) step();
    check("clr_pend_valid", 32'(out_valid), 1);
    check("clr_pend_data", $signed(out_data), 32704);
    check("clr_stall_ready", 32'(in_ready), 0);
    phase_clr = 1'b1;
    en = 1'b1;
    step();
    phase_clr = 1'b0;
    check("clr_flush_valid", 32'(out_valid), 0);
    phase_offset = '0;
    out_ready = 1'b1;
    repeat (2) step();
    en = 1'b0;
    repeat (4) step();
    check("clr_count", q.size(), 2);
    check("clr_s0", q[0], 0);
    check("clr_s1", q[1], 32704);

    // reset mid-stream
    en = 1'b1;
    repeat (4) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_valid", 32'(out_valid), 0);
    check("mrst_addr", 32'(rom_addr), 0);
    check("mrst_data", $signed(out_data), 0);
    en = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("mrst_in_ready", 32'(in_ready), 1);
    check("mrst_valid2", 32'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
